// File: rtl/pe_pkg.sv
// Shared constants and FSM state type for the PE job sequencer.
// Used by pe_mac_seq and its operand/result interface.
package pe_pkg;

    localparam int W_IN   = 8;
    localparam int W_ACC  = 24;
    localparam int LEN_W  = 10;
    localparam int PE_LAT = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        OUT
    } pe_seq_state_t;

endpackage

// File: rtl/pe_mac_seq_if.sv
// Operand stream and result port of the PE job sequencer.
// master = upstream producer / result consumer, slave = sequencer.
interface pe_mac_seq_if #(
    parameter int W_IN  = pe_pkg::W_IN,
    parameter int W_ACC = pe_pkg::W_ACC
) ();

    logic             op_valid;
    logic             op_ready;
    logic [W_IN-1:0]  op_a;
    logic [W_IN-1:0]  op_b;
    logic             res_valid;
    logic             res_ready;
    logic [W_ACC-1:0] res_data;

    modport master (
        output op_valid, op_a, op_b, res_ready,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_a, op_b, res_ready,
        output op_ready, res_valid, res_data
    );

endinterface

// File: rtl/pe_mac_seq.sv
// Dot-product job sequencer feeding one PE core.
// Optional stall counter enabled by defining PE_MAC_SEQ_STALL_CNT_EN.
module pe_mac_seq #(
    parameter int W_IN   = pe_pkg::W_IN,
    parameter int W_ACC  = pe_pkg::W_ACC,
    parameter int LEN_W  = pe_pkg::LEN_W,
    parameter int PE_LAT = pe_pkg::PE_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_relu,
    output logic             busy,
    pe_mac_seq_if.slave      bus,
    output logic             pe_en,
    output logic             pe_mode_sel,
    output logic             pe_reg_reset,
    output logic [W_IN-1:0]  pe_a_mul,
    output logic [W_IN-1:0]  pe_b_mul,
    input  logic [W_ACC-1:0] pe_results,
    output logic [15:0]      stall_cnt
);

    import pe_pkg::*;

    localparam int DW = $clog2(PE_LAT + 1);

    pe_seq_state_t    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             en_q, en_d;
    logic             rst_q, rst_d;
    logic             mode_q, mode_d;
    logic [W_IN-1:0]  a_q, a_d;
    logic [W_IN-1:0]  b_q, b_d;
    logic [W_ACC-1:0] res_q, res_d;
    logic             hs;

    assign hs = bus.op_valid && (state_q == STREAM);

    // Next-state and registered-output logic for the job FSM.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        en_d    = 1'b0;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    mode_d  = cfg_relu;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = '0;
                if (len_q == '0) begin
                    res_d   = '0;
                    state_d = OUT;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    a_d   = bus.op_a;
                    b_d   = bus.op_b;
                    en_d  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DW'(PE_LAT)) begin
                    res_d   = pe_results;
                    state_d = OUT;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            OUT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rst_d = (state_d == CLEAR);
    end

    // State and PE-facing registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            en_q    <= 1'b0;
            rst_q   <= 1'b0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            en_q    <= en_d;
            rst_q   <= rst_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign bus.op_ready  = (state_q == STREAM);
    assign bus.res_valid = (state_q == OUT);
    assign bus.res_data  = res_q;
    assign pe_en         = en_q;
    assign pe_reg_reset  = rst_q;
    assign pe_mode_sel   = mode_q;
    assign pe_a_mul      = a_q;
    assign pe_b_mul      = b_q;

`ifdef PE_MAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of STREAM cycles starved of operands.
    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
        end else if (state_q == STREAM && !bus.op_valid
                     && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_mac_seq.sv
// Directed self-checking bench for pe_mac_seq.
// Includes a behavioural PE so results come from real accumulation.
module tb_pe_mac_seq;

    import pe_pkg::*;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_relu;
    logic             busy;
    logic             pe_en;
    logic             pe_mode_sel;
    logic             pe_reg_reset;
    logic [W_IN-1:0]  pe_a_mul;
    logic [W_IN-1:0]  pe_b_mul;
    logic [W_ACC-1:0] pe_results;
    logic [15:0]      stall_cnt;

    int total;
    int passed;
    int en_cnt;
    int overlap_cnt;

    pe_mac_seq_if #(.W_IN(W_IN), .W_ACC(W_ACC)) bus ();

    pe_mac_seq #(
        .W_IN(W_IN), .W_ACC(W_ACC), .LEN_W(LEN_W), .PE_LAT(PE_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cfg_len(cfg_len),
        .cfg_relu(cfg_relu),
        .busy(busy),
        .bus(bus),
        .pe_en(pe_en),
        .pe_mode_sel(pe_mode_sel),
        .pe_reg_reset(pe_reg_reset),
        .pe_a_mul(pe_a_mul),
        .pe_b_mul(pe_b_mul),
        .pe_results(pe_results),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PE: product stages then accumulate, PE_LAT edges
    // counting the edge that samples pe_en.
    logic signed [W_ACC-1:0] ea, eb, prod;
    logic signed [W_ACC-1:0] p1, p2, p3, acc;
    logic                    v1, v2, v3;

    always_comb begin
        ea   = W_ACC'($signed({1'b0, pe_a_mul}));
        eb   = W_ACC'($signed(pe_b_mul));
        prod = ea * eb;
    end

    always @(posedge clk or posedge reset) begin
        if (reset || pe_reg_reset) begin
            {v1, v2, v3} <= '0;
            p1 <= '0; p2 <= '0; p3 <= '0; acc <= '0;
        end else begin
            v1 <= pe_en; p1 <= prod;
            v2 <= v1;    p2 <= p1;
            v3 <= v2;    p3 <= p2;
            if (v3) acc <= acc + p3;
        end
    end

    assign pe_results = (pe_mode_sel && acc[W_ACC-1]) ? '0 : acc;

    always @(negedge clk) begin
        if (pe_en) en_cnt++;
        if (pe_en && pe_reg_reset) overlap_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len,
                            input logic relu);
        cfg_len  = len;
        cfg_relu = relu;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] a, input logic [7:0] b);
        logic done;
        logic rdy;
        done = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        for (int i = 0; i < 10; i++) begin
            if (!done) begin
                rdy = bus.op_ready;
                tick();
                done = rdy;
            end
        end
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        total++;
        if ({busy, bus.op_ready, bus.res_valid, pe_en, pe_reg_reset,
             pe_mode_sel} !== 6'b0) begin
            $display("FAIL reset_ctrl got %b want 000000",
                     {busy, bus.op_ready, bus.res_valid, pe_en,
                      pe_reg_reset, pe_mode_sel});
        end else passed++;
        total++;
        if (bus.res_data !== 24'h0) begin
            $display("FAIL reset_res got %h want 000000", bus.res_data);
        end else passed++;
        total++;
        if ({pe_a_mul, pe_b_mul} !== 16'h0) begin
            $display("FAIL reset_ops got %h want 0000",
                     {pe_a_mul, pe_b_mul});
        end else passed++;
        total++;
        if (stall_cnt !== 16'h0) begin
            $display("FAIL reset_stall got %0d want 0", stall_cnt);
        end else passed++;
    endtask

    task automatic test_raw();
        int n;
        do_start(10'd3, 1'b0);
        total++;
        if ({pe_reg_reset, pe_en, pe_mode_sel, busy} !== 4'b1001) begin
            $display("FAIL raw_clear got %b want 1001",
                     {pe_reg_reset, pe_en, pe_mode_sel, busy});
        end else passed++;
        send_op(8'd2, 8'd3);
        total++;
        if ({pe_reg_reset, pe_en, pe_a_mul, pe_b_mul}
            !== {2'b01, 8'd2, 8'd3}) begin
            $display("FAIL raw_first_op got %h want %h",
                     {pe_reg_reset, pe_en, pe_a_mul, pe_b_mul},
                     {2'b01, 8'd2, 8'd3});
        end else passed++;
        send_op(8'd4, 8'hFF);
        send_op(8'd1, 8'hF6);
        bus.op_valid = 1'b0;
        total++;
        if (bus.op_ready !== 1'b0) begin
            $display("FAIL raw_ready_drop got %b want 0", bus.op_ready);
        end else passed++;
        wait_res(n);
        total++;
        if (n !== 5) begin
            $display("FAIL raw_latency got %0d want 5", n);
        end else passed++;
        total++;
        if (bus.res_data !== 24'hFFFFF8) begin
            $display("FAIL raw_result got %h want fffff8", bus.res_data);
        end else passed++;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        total++;
        if ({bus.res_valid, busy} !== 2'b00) begin
            $display("FAIL raw_accept got %b want 00",
                     {bus.res_valid, busy});
        end else passed++;
    endtask

    task automatic test_relu();
        int n;
        do_start(10'd3, 1'b1);
        total++;
        if ({pe_reg_reset, pe_mode_sel} !== 2'b11) begin
            $display("FAIL relu_mode got %b want 11",
                     {pe_reg_reset, pe_mode_sel});
        end else passed++;
        send_op(8'd2, 8'd3);
        send_op(8'd4, 8'hFF);
        send_op(8'd1, 8'hF6);
        bus.op_valid = 1'b0;
        wait_res(n);
        total++;
        if (n !== 5 || bus.res_data !== 24'h0) begin
            $display("FAIL relu_result got %h after %0d want 000000 after 5",
                     bus.res_data, n);
        end else passed++;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        do_start(10'd1, 1'b0);
        total++;
        if ({pe_reg_reset, pe_mode_sel} !== 2'b10) begin
            $display("FAIL relu_next_mode got %b want 10",
                     {pe_reg_reset, pe_mode_sel});
        end else passed++;
        send_op(8'd255, 8'h80);
        bus.op_valid = 1'b0;
        wait_res(n);
        total++;
        if (bus.res_data !== 24'hFF8080) begin
            $display("FAIL second_job got %h want ff8080", bus.res_data);
        end else passed++;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        logic [15:0] exp_stall;
`ifdef PE_MAC_SEQ_STALL_CNT_EN
        exp_stall = 16'd4;
`else
        exp_stall = 16'd0;
`endif
        do_start(10'd3, 1'b0);
        send_op(8'd2, 8'd3);
        bus.op_valid = 1'b0;
        tick();
        tick();
        send_op(8'd4, 8'hFF);
        bus.op_valid = 1'b0;
        tick();
        tick();
        send_op(8'd1, 8'hF6);
        bus.op_valid = 1'b0;
        wait_res(n);
        total++;
        if (n !== 5 || bus.res_data !== 24'hFFFFF8) begin
            $display("FAIL stall_result got %h after %0d want fffff8 after 5",
                     bus.res_data, n);
        end else passed++;
        total++;
        if (stall_cnt !== exp_stall) begin
            $display("FAIL stall_cnt got %0d want %0d", stall_cnt, exp_stall);
        end else passed++;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        tick();
        total++;
        if (stall_cnt !== exp_stall) begin
            $display("FAIL stall_hold got %0d want %0d", stall_cnt, exp_stall);
        end else passed++;
    endtask

    task automatic test_backpressure();
        int n;
        do_start(10'd1, 1'b0);
        send_op(8'd3, 8'hFE);
        bus.op_valid = 1'b0;
        wait_res(n);
        for (int i = 0; i < 3; i++) begin
            cfg_len = 10'd2;
            start = 1'b1;
            tick();
            total++;
            if ({bus.res_valid, busy, pe_reg_reset} !== 3'b110
                || bus.res_data !== 24'hFFFFFA) begin
                $display("FAIL bp_hold%0d got %b/%h want 110/fffffa", i,
                         {bus.res_valid, busy, pe_reg_reset}, bus.res_data);
            end else passed++;
        end
        start = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        total++;
        if ({bus.res_valid, busy, pe_reg_reset} !== 3'b000) begin
            $display("FAIL bp_accept got %b want 000",
                     {bus.res_valid, busy, pe_reg_reset});
        end else passed++;
        tick();
        total++;
        if ({busy, pe_reg_reset} !== 2'b00) begin
            $display("FAIL bp_idle got %b want 00", {busy, pe_reg_reset});
        end else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_start(10'd3, 1'b1);
        send_op(8'd1, 8'd1);
        send_op(8'd2, 8'd2);
        bus.op_valid = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if ({busy, bus.op_ready, bus.res_valid, pe_en, pe_reg_reset,
             pe_mode_sel} !== 6'b0) begin
            $display("FAIL mid_reset_ctrl got %b want 000000",
                     {busy, bus.op_ready, bus.res_valid, pe_en,
                      pe_reg_reset, pe_mode_sel});
        end else passed++;
        total++;
        if ({pe_a_mul, pe_b_mul, stall_cnt} !== 32'h0
            || bus.res_data !== 24'h0) begin
            $display("FAIL mid_reset_data got %h/%h want 0/0",
                     {pe_a_mul, pe_b_mul, stall_cnt}, bus.res_data);
        end else passed++;
        #1;
        reset = 1'b0;
        tick();
        do_start(10'd1, 1'b0);
        total++;
        if (pe_reg_reset !== 1'b1) begin
            $display("FAIL mid_clear got %b want 1", pe_reg_reset);
        end else passed++;
        send_op(8'd7, 8'd5);
        bus.op_valid = 1'b0;
        wait_res(n);
        total++;
        if (bus.res_data !== 24'h000023) begin
            $display("FAIL mid_next_job got %h want 000023", bus.res_data);
        end else passed++;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_len0();
        int en0;
        en0 = en_cnt;
        do_start(10'd0, 1'b0);
        total++;
        if ({pe_reg_reset, busy, bus.res_valid} !== 3'b110) begin
            $display("FAIL len0_clear got %b want 110",
                     {pe_reg_reset, busy, bus.res_valid});
        end else passed++;
        tick();
        total++;
        if ({bus.res_valid, bus.op_ready} !== 2'b10
            || bus.res_data !== 24'h0) begin
            $display("FAIL len0_out got %b/%h want 10/000000",
                     {bus.res_valid, bus.op_ready}, bus.res_data);
        end else passed++;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        tick();
        total++;
        if (en_cnt !== en0 || busy !== 1'b0) begin
            $display("FAIL len0_no_en got %0d pe_en cycles busy %b want 0/0",
                     en_cnt - en0, busy);
        end else passed++;
        total++;
        if (overlap_cnt !== 0) begin
            $display("FAIL en_clear_overlap got %0d want 0", overlap_cnt);
        end else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        passed = 0;
        en_cnt = 0;
        overlap_cnt = 0;
        reset = 1'b1;
        start = 1'b0;
        cfg_len = '0;
        cfg_relu = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_raw();
        test_relu();
        test_stall();
        test_backpressure();
        test_reset_mid();
        test_len0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
